servo_channel_loader: RTL and testbench
=======================================

// Module: servo_channel_loader
// PURPOSE
//  Parametrised successor to the servo address decoder. Captures an addressed
//  position word on an active-low latch strobe into per-channel shadow
//  registers. Copies all shadows to the active registers on a PWM frame
//  boundary, so every channel updates glitch-free in the same frame.
//  Adds latch synchronisation, broadcast writes, address range checking and an
//  optional immediate-commit mode. Sits between the host write port and the
//  per-channel PWM generators.
// PARAMETERS
//  CHANNELS     4      number of servo channels (1..2**NBITS)
//  NBITS        2      address width
//  DWIDTH       8      position word width
//  RESET_POS    128    shadow/active value after reset (servo centre)
//  AUTO_COMMIT  0      1: write updates active in the same cycle, frame_tick ignored
// PORTS
//  clk        in   1                 system clock, rising edge
//  rst        in   1                 asynchronous active-high reset
//  address    in   NBITS             target channel
//  data       in   DWIDTH            position word
//  broadcast  in   1                 1: write data to every channel
//  latch_n    in   1                 asynchronous write strobe, active low
//  frame_tick in   1                 1-cycle pulse at PWM frame start
//  load       out  CHANNELS          1-cycle pulse per channel written
//  pos_out    out  CHANNELS*DWIDTH   active positions, ch i at [i*DWIDTH +: DWIDTH]
//  pending    out  1                 shadow differs from active (uncommitted write)
//  updated    out  1                 1-cycle pulse: commit occurred
//  addr_err   out  1                 sticky: last write addressed >= CHANNELS
// BEHAVIOUR
//  Reset (async, rst=1): all shadow and active = RESET_POS.
//   load=0, updated=0, pending=0, addr_err=0.
//   Synchroniser flops = 1, so a strobe held low through reset causes no write.
//  Strobe: latch_n passes through a 2-flop synchroniser plus a delay flop.
//   write_ev = delayed high & synchronised low (one event per falling edge).
//   latch_n first sampled low at edge k -> write executes at edge k+2.
//   address/data/broadcast must be stable from the latch_n fall through edge k+2.
//   Holding latch_n low causes no repeat write. Pulses shorter than 1 clk are
//   not guaranteed.
//  Write at edge k+2, priority order:
//   1. broadcast=1: all shadows <= data; load = all ones; addr_err <= 0.
//   2. address < CHANNELS: shadow[address] <= data; load = one-hot; addr_err <= 0.
//   3. address >= CHANNELS: no shadow change; load = 0; addr_err <= 1.
//      pending unchanged.
//   load is high exactly one cycle and 0 otherwise.
//  Commit FSM (AUTO_COMMIT=0), states CLEAN / PENDING; pending = (state==PENDING).
//   CLEAN  -> PENDING on a valid write (case 1 or 2).
//   PENDING + frame_tick -> all active <= shadow; updated=1 for one cycle; -> CLEAN.
//   CLEAN + frame_tick: no action, updated stays 0.
//   Valid write and frame_tick in the same cycle: commit copies the pre-write
//    shadow. The new word lands in shadow only. State ends PENDING, updated=1.
//  AUTO_COMMIT=1:
//   active and shadow are written at the same edge (pos_out changes at k+2).
//   updated pulses with load; pending is tied 0; frame_tick is ignored.
//  pos_out is driven directly from the active registers, with no
//   combinational path from inputs.
//  Reset mid-operation: takes effect immediately. Any in-flight strobe or
//   pending commit is discarded.
// TESTING
//  1. Reset release, latch_n=1 -> pos_out = {4{8'd128}}, load=0, pending=0, addr_err=0.
//  2. addr=2, data=8'd200, latch_n low 4 clks -> load=4'b0100 for 1 cycle at k+2,
//     pending=1, pos_out unchanged. Next frame_tick -> ch2=200, updated 1 cycle,
//     pending=0.
//  3. broadcast=1, data=8'd50 -> load=4'b1111 once. After frame_tick all channels = 50.
//  4. Write ch1=77 with frame_tick at edge k+2 -> updated=1, ch1 still old value,
//     pending=1. Next frame_tick -> ch1=77.
//  5. NBITS=3, CHANNELS=5: addr=6 -> load=0, addr_err=1, pending unchanged.
//     Next valid write clears addr_err.
//  6. AUTO_COMMIT=1, addr=0, data=8'd10 -> pos_out ch0=10 at k+2, updated with load.
//     Assert rst mid-strobe -> all channels = 128, no load pulse.

Source files
------------

// File: rtl/servo_channel_loader.sv
// Servo channel loader. A host write strobe fills per-channel shadow registers,
// and the shadows are committed together to the active positions on a PWM frame tick.
module servo_channel_loader #(
   parameter int CHANNELS    = 4,
   parameter int NBITS       = 2,
   parameter int DWIDTH      = 8,
   parameter int RESET_POS   = 128,
   parameter int AUTO_COMMIT = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NBITS-1:0]           address,
   input  logic [DWIDTH-1:0]          data,
   input  logic                       broadcast,
   input  logic                       latch_n,
   input  logic                       frame_tick,
   output logic [CHANNELS-1:0]        load,
   output logic [CHANNELS*DWIDTH-1:0] pos_out,
   output logic                       pending,
   output logic                       updated,
   output logic                       addr_err
);

   localparam logic [DWIDTH-1:0] RST_VAL  = DWIDTH'(RESET_POS);
   localparam logic [NBITS:0]    CH_LIMIT = (NBITS + 1)'(CHANNELS);
   localparam bit                AUTO     = (AUTO_COMMIT != 0);

   typedef enum logic {CLEAN, PENDING} state_t;

   state_t              state_reg, state_next;
   logic                sync1_reg, sync2_reg, dly_reg;
   logic                write_ev, in_range, valid_wr, commit;
   logic [CHANNELS-1:0] load_next, load_reg;
   logic                updated_reg, addr_err_reg;

   // All three strobe flops reset high so that reset itself never looks like a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
         dly_reg   <= 1'b1;
      end else begin
         sync1_reg <= latch_n;
         sync2_reg <= sync1_reg;
         dly_reg   <= sync2_reg;
      end
   end

   assign write_ev = dly_reg & ~sync2_reg;
   assign in_range = ({1'b0, address} < CH_LIMIT);
   assign valid_wr = write_ev & (broadcast | in_range);
   assign commit   = !AUTO && (state_reg == PENDING) && frame_tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= CLEAN;
         load_reg     <= '0;
         updated_reg  <= 1'b0;
         addr_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         load_reg    <= load_next;
         updated_reg <= AUTO ? valid_wr : commit;
         if (write_ev)
            addr_err_reg <= ~(broadcast | in_range);
      end
   end

   // A commit and a new write in the same cycle leave the new word uncommitted.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         CLEAN:   if (valid_wr) state_next = PENDING;
         PENDING: if (frame_tick) state_next = valid_wr ? PENDING : CLEAN;
         default: state_next = CLEAN;
      endcase
      if (AUTO)
         state_next = CLEAN;
   end

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi = gi + 1) begin : g_ch
         logic [DWIDTH-1:0] shadow_reg;
         logic [DWIDTH-1:0] active_reg;

         assign load_next[gi] = write_ev & (broadcast | (in_range & (address == NBITS'(gi))));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               shadow_reg <= RST_VAL;
               active_reg <= RST_VAL;
            end else begin
               if (load_next[gi])
                  shadow_reg <= data;
               if (AUTO) begin
                  if (load_next[gi])
                     active_reg <= data;
               end else if (commit) begin
                  active_reg <= shadow_reg;
               end
            end
         end

         assign pos_out[gi*DWIDTH +: DWIDTH] = active_reg;
      end
   endgenerate

   assign load     = load_reg;
   assign updated  = updated_reg;
   assign addr_err = addr_err_reg;
   assign pending  = (state_reg == PENDING);

endmodule

// File: tb/tb_servo_channel_loader.sv
// Bench for servo_channel_loader: a default instance driven from a vector table,
// plus a wide-address instance and an auto-commit instance exercised by hand.
module tb_servo_channel_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  address;
   logic [7:0]  data;
   logic        broadcast, frame_tick;
   logic        latch_n_a, latch_n_b, latch_n_c;

   logic [3:0]  load_a, load_c;
   logic [4:0]  load_b;
   logic [31:0] pos_a, pos_c;
   logic [39:0] pos_b;
   logic        pending_a, updated_a, addr_err_a;
   logic        pending_b, updated_b, addr_err_b;
   logic        pending_c, updated_c, addr_err_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   servo_channel_loader u_a (
      .clk(clk), .rst(rst), .address(address[1:0]), .data(data), .broadcast(broadcast),
      .latch_n(latch_n_a), .frame_tick(frame_tick), .load(load_a), .pos_out(pos_a),
      .pending(pending_a), .updated(updated_a), .addr_err(addr_err_a));

   servo_channel_loader #(.CHANNELS(5), .NBITS(3)) u_b (
      .clk(clk), .rst(rst), .address(address), .data(data), .broadcast(broadcast),
      .latch_n(latch_n_b), .frame_tick(frame_tick), .load(load_b), .pos_out(pos_b),
      .pending(pending_b), .updated(updated_b), .addr_err(addr_err_b));

   servo_channel_loader #(.AUTO_COMMIT(1)) u_c (
      .clk(clk), .rst(rst), .address(address[1:0]), .data(data), .broadcast(broadcast),
      .latch_n(latch_n_c), .frame_tick(frame_tick), .load(load_c), .pos_out(pos_c),
      .pending(pending_c), .updated(updated_c), .addr_err(addr_err_c));

   typedef struct {
      logic        bc;
      logic [1:0]  addr;
      logic [7:0]  data;
      logic        tick_same;
      logic        do_tick;
      logic [3:0]  exp_load;
      logic        exp_upd;
      logic        exp_pend;
      logic [31:0] exp_pos_k2;
      logic [31:0] exp_pos_after;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drop one strobe (0=a, 1=b, 2=c) and return #1 after the write edge k+2.
   task automatic strobe_to_k2(input int which, input logic tick);
      @(negedge clk);
      if (which == 0) latch_n_a = 1'b0;
      if (which == 1) latch_n_b = 1'b0;
      if (which == 2) latch_n_c = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      if (which == 0) chk("a_load_k1", 64'(load_a), 64'h0);
      @(negedge clk);
      frame_tick = tick;
      @(posedge clk);
      #1;
   endtask

   task automatic release_strobe();
      @(negedge clk);
      frame_tick = 1'b0;
      latch_n_a  = 1'b1;
      latch_n_b  = 1'b1;
      latch_n_c  = 1'b1;
      broadcast  = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic tick_once();
      @(negedge clk);
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen_load;
      vecs[0] = '{1'b0, 2'd2, 8'd200, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 32'h80808080, 32'h80C88080};
      vecs[1] = '{1'b1, 2'd0, 8'd50,  1'b0, 1'b1, 4'b1111, 1'b0, 1'b1, 32'h80C88080, 32'h32323232};
      vecs[2] = '{1'b0, 2'd0, 8'h11,  1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 32'h32323232, 32'h32323232};
      vecs[3] = '{1'b0, 2'd1, 8'd77,  1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 32'h32323211, 32'h32324D11};
      vecs[4] = '{1'b1, 2'd3, 8'h05,  1'b0, 1'b1, 4'b1111, 1'b0, 1'b1, 32'h32324D11, 32'h05050505};
      vecs[5] = '{1'b0, 2'd3, 8'hA0,  1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, 32'h05050505, 32'hA0050505};

      rst = 1'b1; address = '0; data = '0; broadcast = 1'b0; frame_tick = 1'b0;
      latch_n_a = 1'b1; latch_n_b = 1'b1; latch_n_c = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_pos", 64'(pos_a), 64'h80808080);
      chk("rst_load", 64'(load_a), 64'h0);
      chk("rst_pending", 64'(pending_a), 64'h0);
      chk("rst_updated", 64'(updated_a), 64'h0);
      chk("rst_addr_err", 64'(addr_err_a), 64'h0);
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         address   = {1'b0, vecs[i].addr};
         data      = vecs[i].data;
         broadcast = vecs[i].bc;
         strobe_to_k2(0, vecs[i].tick_same);
         $display("vec %0d: load=%b pos=%h pending=%b", i, load_a, pos_a, pending_a);
         chk("a_load_k2", 64'(load_a), 64'(vecs[i].exp_load));
         chk("a_updated_k2", 64'(updated_a), 64'(vecs[i].exp_upd));
         chk("a_pending_k2", 64'(pending_a), 64'(vecs[i].exp_pend));
         chk("a_pos_k2", 64'(pos_a), 64'(vecs[i].exp_pos_k2));
         @(negedge clk);
         frame_tick = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         chk("a_no_repeat", 64'(load_a), 64'h0);
         release_strobe();
         @(negedge clk);
         frame_tick = vecs[i].do_tick;
         @(posedge clk);
         #1;
         chk("a_pos_after", 64'(pos_a), 64'(vecs[i].exp_pos_after));
         chk("a_updated_after", 64'(updated_a), 64'(vecs[i].do_tick & vecs[i].exp_pend));
         @(negedge clk);
         frame_tick = 1'b0;
         chk("a_pending_after", 64'(pending_a), 64'(vecs[i].do_tick ? 1'b0 : vecs[i].exp_pend));
         if (i == 4) begin
            tick_once();
            $display("clean tick: updated=%b pos=%h", updated_a, pos_a);
            chk("a_clean_tick_upd", 64'(updated_a), 64'h0);
            chk("a_clean_tick_pos", 64'(pos_a), 64'h05050505);
            @(negedge clk);
            frame_tick = 1'b0;
         end
         repeat (2) @(negedge clk);
      end

      // Out-of-range addressing on the 5-channel, 3-bit-address instance
      address = 3'd6; data = 8'h44;
      strobe_to_k2(1, 1'b0);
      $display("b addr=6: load=%b addr_err=%b pending=%b", load_b, addr_err_b, pending_b);
      chk("b_oor_load", 64'(load_b), 64'h0);
      chk("b_oor_err", 64'(addr_err_b), 64'h1);
      chk("b_oor_pending", 64'(pending_b), 64'h0);
      release_strobe();
      address = 3'd4; data = 8'h09;
      strobe_to_k2(1, 1'b0);
      $display("b addr=4: load=%b addr_err=%b pending=%b", load_b, addr_err_b, pending_b);
      chk("b_valid_load", 64'(load_b), 64'h10);
      chk("b_valid_err", 64'(addr_err_b), 64'h0);
      chk("b_valid_pending", 64'(pending_b), 64'h1);
      release_strobe();
      address = 3'd7; data = 8'h55;
      strobe_to_k2(1, 1'b0);
      $display("b addr=7: load=%b addr_err=%b pending=%b", load_b, addr_err_b, pending_b);
      chk("b_oor2_load", 64'(load_b), 64'h0);
      chk("b_oor2_err", 64'(addr_err_b), 64'h1);
      chk("b_oor2_pending", 64'(pending_b), 64'h1);
      release_strobe();
      tick_once();
      $display("b commit: pos=%h updated=%b", pos_b, updated_b);
      chk("b_commit_pos", 64'(pos_b), 64'h0980808080);
      chk("b_commit_upd", 64'(updated_b), 64'h1);
      @(negedge clk);
      frame_tick = 1'b0;

      // Auto-commit instance
      address = 3'd0; data = 8'd10;
      strobe_to_k2(2, 1'b0);
      $display("c auto: load=%b pos=%h updated=%b", load_c, pos_c, updated_c);
      chk("c_pos_k2", 64'(pos_c), 64'h8080800A);
      chk("c_load_k2", 64'(load_c), 64'h1);
      chk("c_updated_k2", 64'(updated_c), 64'h1);
      chk("c_pending_k2", 64'(pending_c), 64'h0);
      @(posedge clk);
      #1;
      chk("c_updated_k3", 64'(updated_c), 64'h0);
      release_strobe();
      tick_once();
      chk("c_tick_ignored_upd", 64'(updated_c), 64'h0);
      chk("c_tick_ignored_pos", 64'(pos_c), 64'h8080800A);
      @(negedge clk);
      frame_tick = 1'b0;

      // Reset in the middle of a strobe
      address = 3'd1; data = 8'h99;
      @(negedge clk);
      latch_n_c = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      $display("mid-strobe reset: pos_c=%h pos_a=%h", pos_c, pos_a);
      chk("c_rst_pos", 64'(pos_c), 64'h80808080);
      chk("a_rst_pos", 64'(pos_a), 64'h80808080);
      chk("b_rst_pending", 64'(pending_b), 64'h0);
      seen_load = 1'b0;
      @(negedge clk);
      latch_n_c = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         seen_load = seen_load | (|load_c);
      end
      chk("c_rst_no_load", 64'(seen_load), 64'h0);
      chk("c_rst_pos_final", 64'(pos_c), 64'h80808080);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
